// File: rtl/lcd_string_sequencer.sv
// lcd_string_sequencer: streams a latched, sanitised 2-line string to a character-LCD byte interface
module lcd_string_sequencer #(
  parameter int NUM_CHARS = 32,
  parameter int LINE_LEN = 16,
  parameter logic [7:0] LINE1_ADDR = 8'h80,
  parameter logic [7:0] LINE2_ADDR = 8'hC0,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   str_valid,
  output logic                   str_ready,
  input  logic [8*NUM_CHARS-1:0] str_data,
  output logic                   lcd_valid,
  input  logic                   lcd_ready,
  output logic                   lcd_rs,
  output logic [7:0]             lcd_byte,
  output logic                   busy,
  output logic                   done
);
  localparam int IW = $clog2(NUM_CHARS);
  typedef enum logic [2:0] {IDLE, CMD1, DATA1, CMD2, DATA2} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nxt_idx;
  logic [8*NUM_CHARS-1:0] str_q, str_d;
  logic lcd_valid_q, lcd_valid_d, lcd_rs_q, lcd_rs_d, done_q, done_d, xfer;
  logic [7:0] lcd_byte_q, lcd_byte_d, nxt_char;
  function automatic logic [7:0] sanitise(input logic [7:0] c);
    return c == 8'h00 ? PAD_CHAR : (c < 8'h20 || c > 8'h7E) ? 8'h23 : c;
  endfunction
  assign xfer = lcd_valid_q & lcd_ready;
  // the byte preloaded after a transfer is the one at the index the transfer advances to
  assign nxt_idx = (state_q == DATA1 || state_q == DATA2) ? idx_q + IW'(1) : idx_q;
  assign nxt_char = sanitise(str_q[8*(NUM_CHARS-1-int'(nxt_idx)) +: 8]);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    str_d = str_q;
    lcd_valid_d = lcd_valid_q;
    lcd_rs_d = lcd_rs_q;
    lcd_byte_d = lcd_byte_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (str_valid) begin
        state_d = CMD1;
        str_d = str_data;
        idx_d = '0;
        lcd_valid_d = 1'b1;
        lcd_rs_d = 1'b0;
        lcd_byte_d = LINE1_ADDR;
      end
      CMD1: if (xfer) begin
        state_d = DATA1;
        lcd_rs_d = 1'b1;
        lcd_byte_d = nxt_char;
      end
      CMD2: if (xfer) begin
        state_d = DATA2;
        lcd_rs_d = 1'b1;
        lcd_byte_d = nxt_char;
      end
      DATA1: if (xfer) begin
        idx_d = nxt_idx;
        if (idx_q == IW'(LINE_LEN-1)) begin
          state_d = CMD2;
          lcd_rs_d = 1'b0;
          lcd_byte_d = LINE2_ADDR;
        end else begin
          lcd_byte_d = nxt_char;
        end
      end
      DATA2: if (xfer) begin
        if (idx_q == IW'(NUM_CHARS-1)) begin
          state_d = IDLE;
          idx_d = '0;
          lcd_valid_d = 1'b0;
          lcd_rs_d = 1'b0;
          lcd_byte_d = 8'h00;
          done_d = 1'b1;
        end else begin
          idx_d = nxt_idx;
          lcd_byte_d = nxt_char;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      str_q <= '0;
      lcd_valid_q <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_byte_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      str_q <= str_d;
      lcd_valid_q <= lcd_valid_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_byte_q <= lcd_byte_d;
      done_q <= done_d;
    end
  end
  assign str_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign lcd_valid = lcd_valid_q;
  assign lcd_rs = lcd_rs_q;
  assign lcd_byte = lcd_byte_q;
  assign done = done_q;
endmodule

// File: tb/tb_lcd_string_sequencer.sv
// tb_lcd_string_sequencer: scoreboard bench, random strings and lcd_ready patterns against a byte-list model
module tb_lcd_string_sequencer;
  localparam int N = 32;
  localparam int L = 16;
  localparam logic [8*N-1:0] FMT = {"CAP=0x18 ID=0xEF", "TYPE=0x40", 56'h0};
  logic clk = 1'b0, reset = 1'b1, str_valid = 1'b0, lcd_ready = 1'b0;
  logic [8*N-1:0] str_data = '0;
  logic str_ready, lcd_valid, lcd_rs, busy, done;
  logic [7:0] lcd_byte;
  int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  int xfer_cnt = 0, last_xfer_cyc = 0, rdy_mode = 0, hold = 0, exp_total = 0;
  logic pend_done = 1'b0, prev_stall = 1'b0, exp_busy;
  logic [8:0] prev = '0;
  logic [9:0] e;
  logic [15:0] lfsr = 16'hACE1;
  logic [9:0] q[$];
  always #5 clk = ~clk;
  lcd_string_sequencer dut (
    .clk(clk), .reset(reset), .str_valid(str_valid), .str_ready(str_ready),
    .str_data(str_data), .lcd_valid(lcd_valid), .lcd_ready(lcd_ready),
    .lcd_rs(lcd_rs), .lcd_byte(lcd_byte), .busy(busy), .done(done)
  );
  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] san(input logic [7:0] c);
    if (c == 8'h00) return 8'h20;
    if (c < 8'h20 || c >= 8'h7F) return 8'h23;
    return c;
  endfunction
  function automatic logic [8*N-1:0] rand_str();
    logic [8*N-1:0] s;
    int r;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 9);
      s[8*i +: 8] = r == 0 ? 8'h00 : r < 3 ? 8'($urandom_range(1, 31)) :
                    r < 4 ? 8'($urandom_range(127, 255)) : 8'($urandom_range(32, 126));
    end
    return s;
  endfunction
  task automatic push_expected(input logic [8*N-1:0] s);
    q.push_back({2'b00, 8'h80});
    for (int i = 0; i < L; i++) q.push_back({2'b01, san(s[8*(N-1-i) +: 8])});
    q.push_back({2'b00, 8'hC0});
    for (int i = L; i < N; i++) q.push_back({i == N-1, 1'b1, san(s[8*(N-1-i) +: 8])});
  endtask
  task automatic send(input logic [8*N-1:0] s);
    bit ok = 0;
    #1 str_valid = 1'b1;
    str_data = s;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (str_ready && !reset) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      acc_cyc = cyc;
      push_expected(s);
    end
  endtask
  task automatic wait_done(input int target);
    bit ok = 0;
    #1 str_valid = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) begin ok = 1; break; end
    end
    if (!ok) check("done_timeout", done_cnt, target);
    @(posedge clk);
  endtask
  task automatic run(input logic [8*N-1:0] s);
    send(s);
    exp_total++;
    wait_done(exp_total);
  endtask
  initial forever begin
    @(posedge clk); #1;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    case (rdy_mode)
      0: lcd_ready = 1'b1;
      1: begin
        if (lcd_valid && !lcd_rs && hold < 5) begin lcd_ready = 1'b0; hold++; end
        else lcd_ready = lfsr[0];
        if (!(lcd_valid && !lcd_rs)) hold = 0;
      end
      2: lcd_ready = 1'($urandom_range(0, 1));
      default: lcd_ready = 1'b0;
    endcase
  end
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      q.delete();
      pend_done = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("done", int'(done), int'(pend_done));
      pend_done = 1'b0;
      if (done) begin done_cnt++; done_cyc = cyc; end
      exp_busy = q.size() != 0;
      check("busy", int'(busy), int'(exp_busy));
      check("str_ready", int'(str_ready), int'(!exp_busy));
      check("lcd_valid", int'(lcd_valid), int'(exp_busy));
      if (prev_stall) check("stall_stable", int'({lcd_valid, lcd_rs, lcd_byte}), int'({1'b1, prev}));
      if (lcd_valid && lcd_ready && q.size() != 0) begin
        e = q.pop_front();
        check("lcd_rs_byte", int'({lcd_rs, lcd_byte}), int'(e[8:0]));
        pend_done = e[9];
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      prev_stall = lcd_valid && !lcd_ready;
      prev = {lcd_rs, lcd_byte};
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [8*N-1:0] s, s2;
    int a_acc, x0, d0;
    bit ok;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_str_ready", int'(str_ready), 1);
    check("rst_lcd_valid", int'(lcd_valid), 0);
    check("rst_lcd_rs", int'(lcd_rs), 0);
    check("rst_lcd_byte", int'(lcd_byte), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk);
    rdy_mode = 0;
    run(FMT);
    check("done_latency", done_cyc - acc_cyc, 35);
    s = rand_str();
    s[8*N-1 -: 40] = 40'h0A7FC57E20;
    run(s);
    rdy_mode = 1;
    run(FMT);
    run(rand_str());
    rdy_mode = 2;
    repeat (6) run(rand_str());
    rdy_mode = 0;
    s = rand_str();
    s2 = rand_str();
    send(s);
    send(s2);
    check("accept_in_done_cycle", acc_cyc, done_cyc);
    exp_total += 2;
    wait_done(exp_total);
    x0 = xfer_cnt;
    send(rand_str());
    #1 str_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (xfer_cnt >= x0 + 10) begin ok = 1; break; end
    end
    if (!ok) check("xfer_timeout", xfer_cnt, x0 + 10);
    @(posedge clk);
    rdy_mode = 3;
    #1 reset = 1'b1;
    @(posedge clk);
    rdy_mode = 0;
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("abort_lcd_valid", int'(lcd_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_str_ready", int'(str_ready), 1);
    check("abort_done", int'(done), 0);
    @(posedge clk);
    run(FMT);
    d0 = done_cnt;
    send(rand_str());
    a_acc = acc_cyc;
    send(rand_str());
    exp_total += 2;
    wait_done(exp_total);
    check("b2b_span", last_xfer_cyc - a_acc, 69);
    check("b2b_dones", done_cnt - d0, 2);
    repeat (5) @(posedge clk);
    check("done_total", done_cnt, exp_total);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
